fork_join_timer: RTL and testbench
==================================

FORK_JOIN_TIMER -- requirements
Module: fork_join_timer

Interface
REQ-001 Parameter CNT_W, default 8, width of each thread length and countdown counter.
REQ-002 Parameter ELAP_W, default 16, width of elapsed-cycle counter.
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 reset_n  input  1  synchronous active-low reset, sampled on posedge clock.
REQ-005 start  input  1  launch request; sampled high on an edge launches all three threads.
REQ-006 len0, len1, len2  input  CNT_W each  thread lengths in posedges, captured on the launch edge.
REQ-007 join_mode  input  2  captured on launch edge: 00 = JOIN_ALL, 01 = JOIN_ANY, 10 = JOIN_NONE, 11 = treated as JOIN_ALL.
REQ-008 kill  input  1  abort all running threads.
REQ-009 busy  output  1  high while any thread is active.
REQ-010 thr_active  output  3  bit i high while thread i is counting.
REQ-011 thr_done  output  3  bit i one-cycle pulse when thread i completes.
REQ-012 join_done  output  1  one-cycle pulse when the captured join condition is met; at most once per launch.
REQ-013 start_err  output  1  one-cycle pulse when start is rejected.
REQ-014 kill_ack  output  1  one-cycle pulse when a kill is taken.
REQ-015 elapsed  output  ELAP_W  posedges since the last launch edge, saturating at all-ones.

Function
REQ-016 The block SHALL have two states: IDLE (busy=0) and RUN (busy=1).
REQ-017 Launch edge E0: in IDLE with start=1, load cnt_i=len_i, set thr_active[i]=(len_i!=0), clear elapsed to 0, capture join_mode.
REQ-018 E0 SHALL enter RUN if any len_i!=0; otherwise stay IDLE and pulse join_done after E0 in every mode.
REQ-019 At each edge Ek (k>=1) in RUN, every active cnt_i SHALL decrement by 1, and elapsed SHALL increment by 1, saturating.
REQ-020 When cnt_i reaches 0 at edge E(len_i), the block SHALL clear thr_active[i] and pulse thr_done[i] for the cycle after that edge (thread takes exactly len_i posedges).
REQ-021 A thread with len_i=0 SHALL never pulse thr_done[i] and SHALL count as already complete for JOIN_ALL.
REQ-022 JOIN_ALL: join_done SHALL pulse on the edge where the last active thread completes.
REQ-023 JOIN_ANY: join_done SHALL pulse on the edge where the first thread completes; simultaneous completions produce one pulse.
REQ-024 JOIN_NONE: join_done SHALL pulse on E0.
REQ-025 After join_done, the remaining threads SHALL keep counting to completion.
REQ-026 The block SHALL return to IDLE on the edge where no thread remains active.
REQ-027 elapsed SHALL hold its value in IDLE until the next launch.
REQ-028 start=1 in RUN SHALL be ignored, pulse start_err, and leave counters, lengths and mode unchanged.
REQ-029 kill=1 in RUN: on that edge, clear all cnt_i and thr_active, go to IDLE, pulse kill_ack; no thr_done or join_done pulse on that edge.
REQ-030 If kill and a completion fall on the same edge, kill SHALL win.
REQ-031 kill=1 in IDLE SHALL have no effect and SHALL not pulse kill_ack; kill and start together in IDLE SHALL launch normally.
REQ-032 A new launch MAY occur on the edge immediately after the return to IDLE.

Reset
REQ-033 reset_n=0 at an edge SHALL force IDLE with busy=0, thr_active=0, thr_done=0, join_done=0, start_err=0, kill_ack=0, elapsed=0 and all cnt_i=0; this applies mid-run and discards pending completions.
REQ-034 Reset SHALL take priority over start and kill.

Verification
REQ-035 len=10/5/30, JOIN_ALL, start at E0 -> thr_done[1] after E5, thr_done[0] after E10, thr_done[2] and join_done after E30; busy=0 after E30; elapsed=30.
REQ-036 Same lengths, JOIN_ANY -> join_done with thr_done[1] after E5 only; threads 0 and 2 still complete at E10 and E30.
REQ-037 Same lengths, JOIN_NONE -> join_done after E0; busy stays high through E30.
REQ-038 Same lengths, JOIN_ALL, kill at E7 -> thr_done[1] at E5; kill_ack after E7; no further thr_done or join_done; elapsed holds 7.
REQ-039 start asserted again at E3 while running -> start_err pulse after E3; the completion schedule is unchanged.
REQ-040 len=0/0/0 -> join_done after E0, busy never rises; separately, reset_n=0 at E12 of the REQ-035 run -> all outputs 0 after E12 and no later pulses.

Source files
------------

// File: rtl/fork_join_timer.sv
// Purpose: launches three countdown threads at once and signals their join per a captured join mode.
// Latency: a thread of length N completes on the Nth edge after launch; all outputs are registered (busy derives from state).
// Backpressure: none; start while running is rejected with start_err, kill aborts the run with kill_ack.
module fork_join_timer #(
    parameter int CNT_W  = 8,
    parameter int ELAP_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len0,
    input  logic [CNT_W-1:0]  len1,
    input  logic [CNT_W-1:0]  len2,
    input  logic [1:0]        join_mode,
    input  logic              kill,
    output logic              busy,
    output logic [2:0]        thr_active,
    output logic [2:0]        thr_done,
    output logic              join_done,
    output logic              start_err,
    output logic              kill_ack,
    output logic [ELAP_W-1:0] elapsed
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0] MODE_ANY  = 2'b01;
    localparam logic [1:0] MODE_NONE = 2'b10;

    state_t                  state, state_nxt;
    logic [2:0][CNT_W-1:0]   cnt, cnt_nxt;
    logic [2:0][CNT_W-1:0]   len_vec;
    logic [2:0]              act_nxt, done_nxt;
    logic                    join_nxt, serr_nxt, kack_nxt;
    logic [ELAP_W-1:0]       elap_nxt;
    logic [1:0]              mode, mode_nxt;
    // Set once join_done has fired for the current launch, so it never repeats.
    logic                    joined, joined_nxt;

    assign len_vec = {len2, len1, len0};
    assign busy    = (state == RUN);

    // Register all state and pulse outputs; reset wins over everything.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            thr_active <= '0;
            thr_done   <= '0;
            join_done  <= 1'b0;
            start_err  <= 1'b0;
            kill_ack   <= 1'b0;
            elapsed    <= '0;
            mode       <= '0;
            joined     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            thr_active <= act_nxt;
            thr_done   <= done_nxt;
            join_done  <= join_nxt;
            start_err  <= serr_nxt;
            kill_ack   <= kack_nxt;
            elapsed    <= elap_nxt;
            mode       <= mode_nxt;
            joined     <= joined_nxt;
        end
    end

    // Next-state: launch from IDLE, count down / kill / join evaluation in RUN.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        act_nxt    = thr_active;
        done_nxt   = '0;
        join_nxt   = 1'b0;
        serr_nxt   = 1'b0;
        kack_nxt   = 1'b0;
        elap_nxt   = elapsed;
        mode_nxt   = mode;
        joined_nxt = joined;

        case (state)
            IDLE: begin
                // kill alone is ignored here; kill with start still launches.
                if (start) begin
                    cnt_nxt  = len_vec;
                    elap_nxt = '0;
                    mode_nxt = join_mode;
                    for (int i = 0; i < 3; i++) begin
                        act_nxt[i] = (len_vec[i] != '0);
                    end
                    // Nothing to wait for, or no waiting requested: join right away.
                    if ((act_nxt == 3'b000) || (join_mode == MODE_NONE)) begin
                        join_nxt   = 1'b1;
                        joined_nxt = 1'b1;
                    end else begin
                        joined_nxt = 1'b0;
                    end
                    state_nxt = (act_nxt != 3'b000) ? RUN : IDLE;
                end
            end
            RUN: begin
                elap_nxt = (&elapsed) ? elapsed : elapsed + 1'b1;
                serr_nxt = start;
                if (kill) begin
                    cnt_nxt   = '0;
                    act_nxt   = '0;
                    kack_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        if (thr_active[i]) begin
                            cnt_nxt[i] = cnt[i] - 1'b1;
                            if (cnt[i] == CNT_W'(1)) begin
                                act_nxt[i]  = 1'b0;
                                done_nxt[i] = 1'b1;
                            end
                        end
                    end
                    // Any: first completion joins. All (and 11): join when nothing is left running.
                    if (!joined && (done_nxt != 3'b000) &&
                        ((mode == MODE_ANY) || (act_nxt == 3'b000))) begin
                        join_nxt   = 1'b1;
                        joined_nxt = 1'b1;
                    end
                    if (act_nxt == 3'b000) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fork_join_timer.sv
// Bench for fork_join_timer: vector table, directed launch scenarios and random stimulus.
// Every edge is compared against an edge-count based reference model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_fork_join_timer;

    localparam int CNT_W     = 8;
    localparam int ELAP_W    = 5;
    localparam int ELAP_MAX  = (1 << ELAP_W) - 1;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  len0 = '0, len1 = '0, len2 = '0;
    logic [1:0]        join_mode = '0;
    logic              kill = 1'b0;
    logic              busy;
    logic [2:0]        thr_active, thr_done;
    logic              join_done, start_err, kill_ack;
    logic [ELAP_W-1:0] elapsed;

    int total = 0;
    int bad   = 0;

    fork_join_timer #(.CNT_W(CNT_W), .ELAP_W(ELAP_W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .len0(len0), .len1(len1), .len2(len2), .join_mode(join_mode), .kill(kill),
        .busy(busy), .thr_active(thr_active), .thr_done(thr_done),
        .join_done(join_done), .start_err(start_err), .kill_ack(kill_ack),
        .elapsed(elapsed)
    );

    always #5 clock = ~clock;

    // Reference model: run described by launch lengths and edges since launch.
    bit       m_run = 0;
    int       m_len [3];
    logic [1:0] m_mode = 0;
    int       m_k = 0;
    bit       m_joined = 0;
    int       m_elap = 0;
    logic [2:0] m_act = 0, m_done = 0;
    logic     m_busy = 0, m_jd = 0, m_serr = 0, m_kack = 0;

    task automatic model_step(input logic r, s, input logic [CNT_W-1:0] a, b, c,
                              input logic [1:0] md, input logic k);
        m_done = 0; m_jd = 0; m_serr = 0; m_kack = 0;
        if (!r) begin
            m_run = 0; m_act = 0; m_elap = 0; m_joined = 0;
        end else if (!m_run) begin
            if (s) begin
                m_len[0] = int'(a); m_len[1] = int'(b); m_len[2] = int'(c);
                m_mode = md; m_k = 0; m_elap = 0;
                for (int i = 0; i < 3; i++) m_act[i] = (m_len[i] != 0);
                m_run = (m_act != 0);
                m_jd = !m_run || (md == 2'b10);
                m_joined = m_jd;
            end
        end else begin
            m_k++;
            if (m_elap < ELAP_MAX) m_elap++;
            m_serr = s;
            if (k) begin
                m_run = 0; m_act = 0; m_kack = 1;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    m_done[i] = (m_len[i] == m_k);
                    m_act[i]  = (m_len[i] > m_k);
                end
                if (!m_joined && (m_done != 0) && ((m_mode == 2'b01) || (m_act == 0))) begin
                    m_jd = 1; m_joined = 1;
                end
                m_run = (m_act != 0);
            end
        end
        m_busy = m_run;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic check_model();
        check("busy", 32'(busy), 32'(m_busy));
        check("thr_active", 32'(thr_active), 32'(m_act));
        check("thr_done", 32'(thr_done), 32'(m_done));
        check("join_done", 32'(join_done), 32'(m_jd));
        check("start_err", 32'(start_err), 32'(m_serr));
        check("kill_ack", 32'(kill_ack), 32'(m_kack));
        check("elapsed", 32'(elapsed), 32'(m_elap));
    endtask

    // Drive one edge worth of inputs, then sample and compare against the model.
    task automatic apply(input logic r, s, input logic [CNT_W-1:0] a, b, c,
                         input logic [1:0] md, input logic k);
        reset_n = r; start = s; len0 = a; len1 = b; len2 = c; join_mode = md; kill = k;
        @(posedge clock);
        #1;
        model_step(r, s, a, b, c, md, k);
        check_model();
    endtask

    typedef struct {
        logic rst_n, st;
        logic [CNT_W-1:0] l0, l1, l2;
        logic [1:0] md;
        logic kl;
        logic e_busy;
        logic [2:0] e_act, e_done;
        logic e_jd, e_serr, e_kack;
        logic [ELAP_W-1:0] e_elap;
    } vec_t;

    vec_t tbl [11];

    // Recorded events of a directed run (edge index relative to launch E0; -1 = never).
    int jd_edge, jd_cnt, kack_edge, serr_edge, busy_last;
    int d_edge [3];

    task automatic record(input int k);
        if (join_done) begin
            if (jd_edge < 0) jd_edge = k;
            jd_cnt++;
        end
        for (int i = 0; i < 3; i++) if (thr_done[i] && d_edge[i] < 0) d_edge[i] = k;
        if (kill_ack && kack_edge < 0) kack_edge = k;
        if (start_err && serr_edge < 0) serr_edge = k;
        if (busy) busy_last = k;
    endtask

    // Launch 10/5/30 at E0 and run 34 more edges with optional kill/start/reset edges.
    task automatic spec_run(input logic [1:0] md, input int kill_at, start_at, rst_at);
        jd_edge = -1; jd_cnt = 0; kack_edge = -1; serr_edge = -1; busy_last = -1;
        for (int i = 0; i < 3; i++) d_edge[i] = -1;
        apply(1'b1, 1'b1, 8'd10, 8'd5, 8'd30, md, 1'b0);
        record(0);
        for (int k = 1; k <= 34; k++) begin
            apply((rst_at == k) ? 1'b0 : 1'b1, (start_at == k) ? 1'b1 : 1'b0,
                  8'd10, 8'd5, 8'd30, md, (kill_at == k) ? 1'b1 : 1'b0);
            record(k);
        end
    endtask

    initial begin
        // rst st  l0 l1 l2 md kill | busy act done jd serr kack elap
        tbl[0]  = '{0, 0, 0, 0, 0, 2'd0, 0,  0, 3'b000, 3'b000, 0, 0, 0, 5'd0};
        tbl[1]  = '{1, 1, 2, 0, 1, 2'd0, 0,  1, 3'b101, 3'b000, 0, 0, 0, 5'd0};
        tbl[2]  = '{1, 0, 2, 0, 1, 2'd0, 0,  1, 3'b001, 3'b100, 0, 0, 0, 5'd1};
        tbl[3]  = '{1, 0, 2, 0, 1, 2'd0, 0,  0, 3'b000, 3'b001, 1, 0, 0, 5'd2};
        tbl[4]  = '{1, 0, 0, 0, 0, 2'd0, 0,  0, 3'b000, 3'b000, 0, 0, 0, 5'd2};
        tbl[5]  = '{1, 0, 0, 0, 0, 2'd0, 1,  0, 3'b000, 3'b000, 0, 0, 0, 5'd2};
        tbl[6]  = '{1, 1, 0, 0, 0, 2'd1, 0,  0, 3'b000, 3'b000, 1, 0, 0, 5'd0};
        tbl[7]  = '{1, 1, 3, 3, 3, 2'd2, 1,  1, 3'b111, 3'b000, 1, 0, 0, 5'd0};
        tbl[8]  = '{1, 1, 3, 3, 3, 2'd2, 0,  1, 3'b111, 3'b000, 0, 1, 0, 5'd1};
        tbl[9]  = '{1, 0, 3, 3, 3, 2'd2, 1,  0, 3'b000, 3'b000, 0, 0, 1, 5'd2};
        tbl[10] = '{1, 0, 0, 0, 0, 2'd0, 0,  0, 3'b000, 3'b000, 0, 0, 0, 5'd2};

        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].rst_n, tbl[i].st, tbl[i].l0, tbl[i].l1, tbl[i].l2, tbl[i].md, tbl[i].kl);
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
            check($sformatf("vec%0d act", i), 32'(thr_active), 32'(tbl[i].e_act));
            check($sformatf("vec%0d done", i), 32'(thr_done), 32'(tbl[i].e_done));
            check($sformatf("vec%0d join", i), 32'(join_done), 32'(tbl[i].e_jd));
            check($sformatf("vec%0d serr", i), 32'(start_err), 32'(tbl[i].e_serr));
            check($sformatf("vec%0d kack", i), 32'(kill_ack), 32'(tbl[i].e_kack));
            check($sformatf("vec%0d elap", i), 32'(elapsed), 32'(tbl[i].e_elap));
        end

        // Join-all schedule.
        spec_run(2'b00, -1, -1, -1);
        check("all join edge", jd_edge, 30);
        check("all join count", jd_cnt, 1);
        check("all done0 edge", d_edge[0], 10);
        check("all done1 edge", d_edge[1], 5);
        check("all done2 edge", d_edge[2], 30);
        check("all busy last", busy_last, 29);
        check("all elapsed", 32'(elapsed), 30);

        // Join-any: one join at the first completion, others still finish.
        spec_run(2'b01, -1, -1, -1);
        check("any join edge", jd_edge, 5);
        check("any join count", jd_cnt, 1);
        check("any done0 edge", d_edge[0], 10);
        check("any done2 edge", d_edge[2], 30);

        // Join-none: join at launch, busy through E29.
        spec_run(2'b10, -1, -1, -1);
        check("none join edge", jd_edge, 0);
        check("none busy last", busy_last, 29);

        // Kill at E7.
        spec_run(2'b00, 7, -1, -1);
        check("kill done1 edge", d_edge[1], 5);
        check("kill done0 none", d_edge[0], -1);
        check("kill done2 none", d_edge[2], -1);
        check("kill ack edge", kack_edge, 7);
        check("kill join none", jd_cnt, 0);
        check("kill elapsed", 32'(elapsed), 7);

        // Restart attempt at E3.
        spec_run(2'b00, -1, 3, -1);
        check("restart serr edge", serr_edge, 3);
        check("restart join edge", jd_edge, 30);
        check("restart done0 edge", d_edge[0], 10);

        // Reset at E12.
        spec_run(2'b00, -1, -1, 12);
        check("rst done0 edge", d_edge[0], 10);
        check("rst done2 none", d_edge[2], -1);
        check("rst join none", jd_cnt, 0);
        check("rst busy last", busy_last, 11);
        check("rst elapsed", 32'(elapsed), 0);

        // All-zero lengths.
        apply(1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 2'b00, 1'b0);
        check("zero join", 32'(join_done), 1);
        check("zero busy", 32'(busy), 0);
        apply(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 2'b00, 1'b0);
        check("zero busy after", 32'(busy), 0);

        // Elapsed saturation with a 40-edge thread.
        apply(1'b1, 1'b1, 8'd40, 8'd0, 8'd0, 2'b11, 1'b0);
        for (int k = 0; k < 42; k++) apply(1'b1, 1'b0, 8'd40, 8'd0, 8'd0, 2'b11, 1'b0);
        check("sat elapsed", 32'(elapsed), ELAP_MAX);
        check("sat idle", 32'(busy), 0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            apply(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) == 0),
                  CNT_W'($urandom_range(0, 12)), CNT_W'($urandom_range(0, 12)),
                  CNT_W'($urandom_range(0, 12)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
